uart_tx: RTL and testbench
==========================

Name: uart_tx

Overview:
- Serial transmitter directly downstream of the UART control FSM.
- Accepts one byte per tx_req pulse from D-memory read data and serialises it as 8N1 (optionally 8E1) on the TX pin.
- Reports tx_empty, whose rising edge paces the controller's next D-memory read, and tx_error on overrun.
- Double-buffered: one holding register feeds one shift register.

Parameters:
- CLK_FREQ_HZ, 10_000_000, system clock frequency.
- BAUD_RATE, 115_200, serial bit rate.
- STOP_BITS, 1, number of stop bits; legal values 1 or 2.
- CLKS_PER_BIT (localparam) = CLK_FREQ_HZ / BAUD_RATE, integer-truncated; must be >= 2, enforced by elaboration-time assertion.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- tx_req  input  1  single-cycle byte-load strobe.
- tx_data  input  8  byte to send; sampled on the edge where tx_req=1.
- tx_error_clr  input  1  clears sticky tx_error.
- tx_empty  output  1  holding register empty, ready for tx_req.
- tx_busy  output  1  frame in progress (shifter FSM not IDLE).
- tx_error  output  1  sticky overrun flag.
- tx_serial  output  1  UART TX line; idles high; registered.

Behaviour:
- Reset (async assert, sync-deasserted externally):
  - tx_serial=1, tx_empty=1, tx_busy=0, tx_error=0.
  - FSM=IDLE, baud counter=0, bit index=0, holding register cleared.
  - Reset mid-frame aborts the frame immediately; the line goes high with no glitch low.
- Holding register:
  - Accepts a byte on an edge with tx_req=1 and hold_valid=0.
  - tx_empty = !hold_valid, a direct register decode.
- Overrun:
  - tx_req while hold_valid=1 drops the byte, leaves the holding register unchanged, and sets tx_error.
  - Set wins over a simultaneous tx_error_clr.
  - tx_error_clr alone clears tx_error on the next edge.
- Transfer to shifter: on any edge with FSM in IDLE and hold_valid=1:
  - shifter<=hold, hold_valid<=0, FSM<=START, tx_serial<=0, baud counter<=CLKS_PER_BIT-1.
- Latency:
  - tx_req sampled at edge N → tx_empty low after N.
  - With the shifter idle: tx_serial low and tx_empty high again after N+1.
  - A tx_req arriving in the same edge as the transfer sees hold_valid=1 and is an overrun.
- FSM states: IDLE, START, DATA, PARITY (only with the optional feature), STOP.
  - Each non-IDLE state holds tx_serial for exactly CLKS_PER_BIT clocks.
  - The baud counter decrements to 0; at 0 it reloads CLKS_PER_BIT-1 and advances.
- DATA:
  - 8 bits, LSB first; bit index 0..7.
  - After bit 7: go to PARITY if enabled, else STOP.
- STOP:
  - tx_serial=1 for STOP_BITS*CLKS_PER_BIT clocks.
  - At the end: go to START (load next byte, same edge) if hold_valid=1, else IDLE.
  - Back-to-back frames therefore have no idle gap.
- tx_busy = (FSM != IDLE).
- Frame length: (10 + parity + STOP_BITS-1) * CLKS_PER_BIT clocks.
- Controller interaction:
  - tx_empty falls then rises for every accepted byte, so an edge detector on tx_empty yields exactly one rising edge per byte.
  - tx_data must be valid in the tx_req cycle.
- Widths:
  - Baud counter is $clog2(CLKS_PER_BIT) bits, wraps only by reload.
  - Bit index is 3 bits.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- Defined:
  - PARITY state inserted between DATA and STOP.
  - Drives the even-parity bit (XOR of the 8 data bits, captured at load) for CLKS_PER_BIT clocks.
  - Frame is 11 bits with STOP_BITS=1.
- Undefined:
  - No PARITY state, no parity register.
  - 8N1 framing exactly as above.

Test Plan:
- CLK_FREQ_HZ=10_000_000, BAUD_RATE=1_000_000 (CLKS_PER_BIT=10), tx_data=8'hA5 with one tx_req:
  - tx_serial low 10 clks, then 1,0,1,0,0,1,0,1 at 10 clks each, then high 10 clks.
  - tx_busy high for 100 clks; tx_empty low exactly 1 clk.
- Bytes 8'h00 then 8'hFF, second tx_req 5 clks after the first:
  - Second byte held (tx_empty low) until the first frame's stop ends.
  - Start bit of frame 2 follows stop of frame 1 with zero idle clocks; tx_error=0.
- Three tx_req back-to-back (8'h11, 8'h22, 8'h33):
  - 8'h11 and 8'h22 transmitted; 8'h33 dropped; tx_error=1 and stays 1.
  - tx_error_clr pulse clears it; a simultaneous new overrun with clr leaves tx_error=1.
- rst_n asserted 37 clks into the frame for 8'h3C:
  - tx_serial=1 and tx_busy=0 immediately (before the next edge); tx_empty=1.
  - After release, 8'h5A transmits correctly.
- STOP_BITS=2, 8'hC3 at CLKS_PER_BIT=10: stop high 20 clks; frame 110 clks.
- With UART_TX_PARITY_EN:
  - 8'h07 → parity bit 1 after data bit 7; frame 110 clks (STOP_BITS=1).
  - 8'h03 → parity bit 0.

Source files
------------

// File: rtl/uart_tx_if.sv
// uart_tx_if: byte-load handshake and status bundle between controller and UART TX.
// master = controller (req/data/clr out), slave = transmitter (status and line out).
interface uart_tx_if;
  logic       tx_req;
  logic [7:0] tx_data;
  logic       tx_error_clr;
  logic       tx_empty;
  logic       tx_busy;
  logic       tx_error;
  logic       tx_serial;

  modport master (
    output tx_req,
    output tx_data,
    output tx_error_clr,
    input  tx_empty,
    input  tx_busy,
    input  tx_error,
    input  tx_serial
  );

  modport slave (
    input  tx_req,
    input  tx_data,
    input  tx_error_clr,
    output tx_empty,
    output tx_busy,
    output tx_error,
    output tx_serial
  );
endinterface

// File: rtl/uart_tx.sv
// uart_tx: double-buffered 8N1 serialiser (8E1 when UART_TX_PARITY_EN is defined).
// Ports: clk, rst_n (async low); bus = uart_tx_if.slave (req/data/clr in; empty/busy/error/serial out).
module uart_tx #(
  parameter int CLK_FREQ_HZ = 10_000_000,
  parameter int BAUD_RATE   = 115_200,
  parameter int STOP_BITS   = 1
) (
  input  logic     clk,
  input  logic     rst_n,
  uart_tx_if.slave bus
);
  localparam int CLKS_PER_BIT = CLK_FREQ_HZ / BAUD_RATE;
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] RELOAD = CW'(CLKS_PER_BIT - 1);
  localparam logic [2:0] LAST_STOP = 3'(STOP_BITS - 1);

  if (CLKS_PER_BIT < 2) begin : g_bad_cpb
    $error("uart_tx: CLKS_PER_BIT must be >= 2");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
    $error("uart_tx: STOP_BITS must be 1 or 2");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_TX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bidx_q, bidx_d;
  logic [7:0]    sh_q, sh_d;
  logic [7:0]    hold_q, hold_d;
  logic          hv_q, hv_d;
  logic          err_q, err_d;
  logic          ser_q, ser_d;
`ifdef UART_TX_PARITY_EN
  logic          par_q, par_d;
`endif
  logic          xfer;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bidx_q  <= '0;
      sh_q    <= '0;
      hold_q  <= '0;
      hv_q    <= 1'b0;
      err_q   <= 1'b0;
      ser_q   <= 1'b1;
`ifdef UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bidx_q  <= bidx_d;
      sh_q    <= sh_d;
      hold_q  <= hold_d;
      hv_q    <= hv_d;
      err_q   <= err_d;
      ser_q   <= ser_d;
`ifdef UART_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bidx_d  = bidx_q;
    sh_d    = sh_q;
    hold_d  = hold_q;
    hv_d    = hv_q;
    err_d   = err_q;
    ser_d   = ser_q;
`ifdef UART_TX_PARITY_EN
    par_d   = par_q;
`endif
    xfer    = 1'b0;

    // a request against a full holding register is dropped
    if (bus.tx_req && !hv_q) begin
      hold_d = bus.tx_data;
      hv_d   = 1'b1;
    end
    if (bus.tx_req && hv_q) begin
      err_d = 1'b1;
    end else if (bus.tx_error_clr) begin
      err_d = 1'b0;
    end

    unique case (state_q)
      S_IDLE: begin
        if (hv_q) xfer = 1'b1;
      end
      S_START: begin
        if (cnt_q == '0) begin
          cnt_d   = RELOAD;
          bidx_d  = '0;
          state_d = S_DATA;
          ser_d   = sh_q[0];
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_DATA: begin
        if (cnt_q == '0) begin
          cnt_d = RELOAD;
          if (bidx_q == 3'd7) begin
            bidx_d = '0;
`ifdef UART_TX_PARITY_EN
            state_d = S_PARITY;
            ser_d   = par_q;
`else
            state_d = S_STOP;
            ser_d   = 1'b1;
`endif
          end else begin
            bidx_d = bidx_q + 3'd1;
            sh_d   = sh_q >> 1;
            ser_d  = sh_q[1];
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (cnt_q == '0) begin
          cnt_d   = RELOAD;
          bidx_d  = '0;
          state_d = S_STOP;
          ser_d   = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
`endif
      S_STOP: begin
        if (cnt_q == '0) begin
          // bit index doubles as the stop-bit counter
          if (bidx_q == LAST_STOP) begin
            if (hv_q) xfer = 1'b1;
            else state_d = S_IDLE;
          end else begin
            cnt_d  = RELOAD;
            bidx_d = bidx_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // shifter load; also chains the next frame straight off the stop bit
    if (xfer) begin
      sh_d    = hold_q;
      hv_d    = 1'b0;
      state_d = S_START;
      ser_d   = 1'b0;
      cnt_d   = RELOAD;
      bidx_d  = '0;
`ifdef UART_TX_PARITY_EN
      par_d   = ^hold_q;
`endif
    end
  end

  assign bus.tx_empty  = !hv_q;
  assign bus.tx_busy   = (state_q != S_IDLE);
  assign bus.tx_error  = err_q;
  assign bus.tx_serial = ser_q;
endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: directed checks of uart_tx framing, buffering, overrun and reset.
// Two instances: STOP_BITS=1 (dut 0) and STOP_BITS=2 (dut 1), CLKS_PER_BIT=10.
module tb_uart_tx;
  localparam int CLK_HZ = 10_000_000;
  localparam int BAUD   = 1_000_000;
  localparam int CPB    = 10;
`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  uart_tx_if bus0 ();
  uart_tx_if bus1 ();

  uart_tx #(
    .CLK_FREQ_HZ(CLK_HZ),
    .BAUD_RATE(BAUD),
    .STOP_BITS(1)
  ) u0 (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus0)
  );

  uart_tx #(
    .CLK_FREQ_HZ(CLK_HZ),
    .BAUD_RATE(BAUD),
    .STOP_BITS(2)
  ) u1 (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus1)
  );

  int n_chk = 0;
  int n_fail = 0;

  typedef struct {
    logic [7:0]  data;
    int          dut;
    int          nbits;
    logic [11:0] frame;
  } vec_t;

  vec_t vt[$];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic f_ser(input int w);
    return (w == 1) ? bus1.tx_serial : bus0.tx_serial;
  endfunction
  function automatic logic f_busy(input int w);
    return (w == 1) ? bus1.tx_busy : bus0.tx_busy;
  endfunction
  function automatic logic f_empty(input int w);
    return (w == 1) ? bus1.tx_empty : bus0.tx_empty;
  endfunction
  function automatic logic f_err(input int w);
    return (w == 1) ? bus1.tx_error : bus0.tx_error;
  endfunction

  // frame bits LSB first: start, data, [parity], stop
  function automatic logic [11:0] frm(input logic [7:0] d);
`ifdef UART_TX_PARITY_EN
    return {1'b0, 1'b1, ^d, d, 1'b0};
`else
    return {2'b00, 1'b1, d, 1'b0};
`endif
  endfunction

  task automatic setreq(input int w, input logic r, input logic [7:0] d,
                        input logic c);
    if (w == 1) begin
      bus1.tx_req = r;
      bus1.tx_data = d;
      bus1.tx_error_clr = c;
    end else begin
      bus0.tx_req = r;
      bus0.tx_data = d;
      bus0.tx_error_clr = c;
    end
  endtask

  // Called on the negedge holding sample index 'skip' of the frame
  // (index 0 = first negedge after the transfer edge).
  task automatic run_frame(input string nm, input int w,
                           input logic [11:0] exp, input int nbits,
                           input int skip, input int exp_elo);
    int bad[12];
    int busy_n;
    int elo;
    busy_n = 0;
    elo = 0;
    for (int b = 0; b < 12; b++) bad[b] = 0;
    for (int s = skip; s < nbits * CPB; s++) begin
      if (f_ser(w) !== exp[s / CPB]) bad[s / CPB]++;
      if (f_busy(w) === 1'b1) busy_n++;
      if (f_empty(w) === 1'b0) elo++;
      @(negedge clk);
    end
    for (int b = skip / CPB; b < nbits; b++)
      chk($sformatf("%s bit%0d bad samples", nm, b), bad[b], 0);
    chk($sformatf("%s busy clks", nm), busy_n, nbits * CPB - skip);
    chk($sformatf("%s empty-low clks", nm), elo, exp_elo);
  endtask

  initial begin
`ifdef UART_TX_PARITY_EN
    vt.push_back('{8'hA5, 0, 11, 12'b0_1_0_10100101_0});
    vt.push_back('{8'hC3, 1, 12, 12'b11_0_11000011_0});
    vt.push_back('{8'h07, 0, 11, 12'b0_1_1_00000111_0});
    vt.push_back('{8'h03, 0, 11, 12'b0_1_0_00000011_0});
`else
    vt.push_back('{8'hA5, 0, 10, 12'b00_1_10100101_0});
    vt.push_back('{8'hC3, 1, 11, 12'b0_11_11000011_0});
`endif

    rst_n = 1'b0;
    setreq(0, 1'b0, 8'h00, 1'b0);
    setreq(1, 1'b0, 8'h00, 1'b0);
    repeat (3) @(negedge clk);
    chk("rst serial", bus0.tx_serial, 1);
    chk("rst empty", bus0.tx_empty, 1);
    chk("rst busy", bus0.tx_busy, 0);
    chk("rst error", bus0.tx_error, 0);
    chk("rst serial dut1", bus1.tx_serial, 1);
    rst_n = 1'b1;
    @(negedge clk);

    foreach (vt[i]) begin
      setreq(vt[i].dut, 1'b1, vt[i].data, 1'b0);
      @(negedge clk);
      setreq(vt[i].dut, 1'b0, 8'h00, 1'b0);
      chk($sformatf("v%0d empty after req", i), f_empty(vt[i].dut), 0);
      chk($sformatf("v%0d serial before xfer", i), f_ser(vt[i].dut), 1);
      chk($sformatf("v%0d busy before xfer", i), f_busy(vt[i].dut), 0);
      @(negedge clk);
      chk($sformatf("v%0d empty after xfer", i), f_empty(vt[i].dut), 1);
      run_frame($sformatf("v%0d", i), vt[i].dut, vt[i].frame,
                vt[i].nbits, 0, 0);
      chk($sformatf("v%0d busy end", i), f_busy(vt[i].dut), 0);
      chk($sformatf("v%0d serial end", i), f_ser(vt[i].dut), 1);
      chk($sformatf("v%0d error", i), f_err(vt[i].dut), 0);
      @(negedge clk);
    end

    // 00 then FF, second request 5 clocks after the first
    setreq(0, 1'b1, 8'h00, 1'b0);
    @(negedge clk);
    setreq(0, 1'b0, 8'h00, 1'b0);
    repeat (4) @(negedge clk);
    setreq(0, 1'b1, 8'hFF, 1'b0);
    @(negedge clk);
    setreq(0, 1'b0, 8'h00, 1'b0);
    chk("b2b held", bus0.tx_empty, 0);
    run_frame("b2b 00", 0, frm(8'h00), NB, 4, NB * CPB - 4);
    chk("b2b empty at f2", bus0.tx_empty, 1);
    run_frame("b2b FF", 0, frm(8'hFF), NB, 0, 0);
    chk("b2b busy end", bus0.tx_busy, 0);
    chk("b2b error", bus0.tx_error, 0);
    @(negedge clk);

    // 11, 22 (once 11 reaches the shifter), 33 straight after: overrun
    setreq(0, 1'b1, 8'h11, 1'b0);
    @(negedge clk);
    setreq(0, 1'b0, 8'h00, 1'b0);
    @(negedge clk);
    setreq(0, 1'b1, 8'h22, 1'b0);
    @(negedge clk);
    setreq(0, 1'b1, 8'h33, 1'b0);
    @(negedge clk);
    setreq(0, 1'b0, 8'h00, 1'b0);
    chk("ovr error set", bus0.tx_error, 1);
    chk("ovr 22 held", bus0.tx_empty, 0);
    run_frame("ovr 11", 0, frm(8'h11), NB, 2, NB * CPB - 2);
    chk("ovr error mid", bus0.tx_error, 1);
    run_frame("ovr 22", 0, frm(8'h22), NB, 0, 0);
    chk("ovr 33 dropped", bus0.tx_busy, 0);
    chk("ovr error sticky", bus0.tx_error, 1);
    setreq(0, 1'b0, 8'h00, 1'b1);
    @(negedge clk);
    setreq(0, 1'b0, 8'h00, 1'b0);
    chk("clr error", bus0.tx_error, 0);

    // request on the transfer edge is an overrun; set beats clear
    setreq(0, 1'b1, 8'h44, 1'b0);
    @(negedge clk);
    setreq(0, 1'b1, 8'h55, 1'b1);
    @(negedge clk);
    setreq(0, 1'b0, 8'h00, 1'b0);
    chk("set beats clr", bus0.tx_error, 1);
    run_frame("ovr 44", 0, frm(8'h44), NB, 0, 0);
    chk("55 dropped", bus0.tx_busy, 0);
    setreq(0, 1'b0, 8'h00, 1'b1);
    @(negedge clk);
    setreq(0, 1'b0, 8'h00, 1'b0);
    chk("clr error 2", bus0.tx_error, 0);

    // reset 37 clocks into the 3C frame
    setreq(0, 1'b1, 8'h3C, 1'b0);
    @(negedge clk);
    setreq(0, 1'b0, 8'h00, 1'b0);
    @(negedge clk);
    chk("3C start", bus0.tx_serial, 0);
    repeat (37) @(negedge clk);
    chk("3C busy pre-reset", bus0.tx_busy, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("mid rst serial", bus0.tx_serial, 1);
    chk("mid rst busy", bus0.tx_busy, 0);
    chk("mid rst empty", bus0.tx_empty, 1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post rst serial", bus0.tx_serial, 1);
    setreq(0, 1'b1, 8'h5A, 1'b0);
    @(negedge clk);
    setreq(0, 1'b0, 8'h00, 1'b0);
    @(negedge clk);
    run_frame("5A", 0, frm(8'h5A), NB, 0, 0);
    chk("5A busy end", bus0.tx_busy, 0);
    chk("5A serial end", bus0.tx_serial, 1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
